// File: rtl/change_payout_controller.sv
// Coin-return sequencer: fires the ejector once per coin owed, confirms each coin on the
// drop sensor, re-attempts missed coins and reports completion (done) or a stuck ejector (fault).
module change_payout_controller #(
   parameter int CLK_FREQ_HZ   = 50_000_000,
   parameter int AMT_W         = 4,
   parameter int PULSE_CYCLES  = 2_500_000,
   parameter int GAP_CYCLES    = 2_500_000,
   parameter int SENSE_TIMEOUT = 5_000_000,
   parameter int MAX_RETRY     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   input  logic             abort,
   input  logic             fault_clr,
   input  logic             coin_seen,
   output logic             eject,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [AMT_W-1:0] remaining,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {S_IDLE, S_PULSE, S_WAIT, S_GAP, S_FAULT} state_t;

   localparam int CMAX = (PULSE_CYCLES > GAP_CYCLES)
                         ? ((PULSE_CYCLES > SENSE_TIMEOUT) ? PULSE_CYCLES : SENSE_TIMEOUT)
                         : ((GAP_CYCLES > SENSE_TIMEOUT) ? GAP_CYCLES : SENSE_TIMEOUT);
   localparam int TW = $clog2(CMAX + 1);
   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] SENSE_LAST = TW'(SENSE_TIMEOUT - 1);

   if (CLK_FREQ_HZ <= 0 || PULSE_CYCLES < 1 || GAP_CYCLES < 1 || SENSE_TIMEOUT < 1) begin : g_bad_cfg
      $error("change_payout_controller: clock and timing parameters must be positive");
   end

   state_t          state;
   logic [TW-1:0]   timer;
   logic [RW-1:0]   retry;
   logic            seen;
   logic            coin_prev;
   logic            coin_rise;

   assign coin_rise = coin_seen & ~coin_prev;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         timer     <= '0;
         retry     <= '0;
         seen      <= 1'b0;
         coin_prev <= 1'b0;
         eject     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fault     <= 1'b0;
         remaining <= '0;
      end else begin
         coin_prev <= coin_seen;
         done      <= 1'b0;
         // Only the first sensor edge of an attempt matters; later ones re-set the same flag.
         if ((state == S_PULSE || state == S_WAIT) && coin_rise)
            seen <= 1'b1;

         if (abort && state != S_IDLE) begin
            state <= S_IDLE;
            eject <= 1'b0;
            busy  <= 1'b0;
            fault <= 1'b0;
            timer <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     if (amount != '0) begin
                        remaining <= amount;
                        retry     <= '0;
                        seen      <= 1'b0;
                        timer     <= '0;
                        eject     <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_PULSE;
                     end else begin
                        done <= 1'b1;
                     end
                  end
               end
               S_PULSE: begin
                  if (timer == PULSE_LAST) begin
                     timer <= '0;
                     eject <= 1'b0;
                     state <= S_WAIT;
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end
               S_WAIT: begin
                  if (seen) begin
                     timer <= '0;
                     retry <= '0;
                     if (remaining != '0)
                        remaining <= remaining - AMT_W'(1);
                     if (remaining <= AMT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                     end else begin
                        state <= S_GAP;
                     end
                  end else if (timer == SENSE_LAST) begin
                     // Missed coin: retry counts extra attempts beyond the first.
                     timer <= '0;
                     retry <= retry + RW'(1);
                     if (retry >= RW'(MAX_RETRY)) begin
                        fault <= 1'b1;
                        state <= S_FAULT;
                     end else begin
                        state <= S_GAP;
                     end
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end
               S_GAP: begin
                  seen <= 1'b0;
                  if (timer == GAP_LAST) begin
                     timer <= '0;
                     eject <= 1'b1;
                     state <= S_PULSE;
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end
               S_FAULT: begin
                  if (fault_clr) begin
                     fault <= 1'b0;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end
               default: begin
                  eject <= 1'b0;
                  busy  <= 1'b0;
                  fault <= 1'b0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_change_payout_controller.sv
// Bench for change_payout_controller: each payout is expanded into a per-cycle timeline of
// expected outputs (pulse/wait/gap segment lengths) and replayed against the DUT.
module tb_change_payout_controller;

   localparam int P  = 4;
   localparam int G  = 3;
   localparam int S  = 8;
   localparam int MR = 2;

   localparam logic [7:0] S_ABORT = 8'h80;
   localparam logic [7:0] S_CLR   = 8'h40;
   localparam logic [7:0] S_START = 8'h20;
   localparam logic [7:0] S_COIN  = 8'h10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] amount = '0;
   logic       abort = 1'b0;
   logic       fault_clr = 1'b0;
   logic       coin_seen = 1'b0;
   logic       eject, busy, done, fault;
   logic [3:0] remaining;
   logic [2:0] dbg_state;
   logic [7:0] obs;

   change_payout_controller #(
      .AMT_W(4), .PULSE_CYCLES(P), .GAP_CYCLES(G), .SENSE_TIMEOUT(S), .MAX_RETRY(MR)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .amount(amount), .abort(abort),
      .fault_clr(fault_clr), .coin_seen(coin_seen), .eject(eject), .busy(busy),
      .done(done), .fault(fault), .remaining(remaining), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   assign obs = {fault, busy, done, eject, remaining};

   // Per-step stimulus {abort, fault_clr, start, coin_seen, amount} and the outputs expected after that edge.
   logic [7:0] stim_q[$];
   logic [7:0] exp_q[$];
   int         n_vec = 0;
   int         n_bad = 0;
   int         abort_at = -1;
   bit         aborted = 1'b0;
   logic [3:0] model_rem = '0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got {fault,busy,done,eject,rem}=%b, want %b", tag, got, want);
      end
   endtask

   function automatic logic [7:0] pk(input logic f, input logic b, input logic d,
                                     input logic e, input logic [3:0] r);
      return {f, b, d, e, r};
   endfunction

   task automatic push(input logic [7:0] s, input logic [7:0] e);
      logic [7:0] last;
      if (aborted) return;
      if (stim_q.size() == abort_at) begin
         last = exp_q[exp_q.size() - 1];
         stim_q.push_back(s | S_ABORT);
         exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, last[3:0]));
         aborted = 1'b1;
      end else begin
         stim_q.push_back(s);
         exp_q.push_back(e);
      end
   endtask

   task automatic patch_coin(input int idx);
      logic [7:0] t;
      if (idx < stim_q.size()) begin
         t = stim_q[idx];
         t = t | S_COIN;
         stim_q[idx] = t;
      end
   endtask

   task automatic idle(input int n);
      abort_at = -1;
      aborted  = 1'b0;
      repeat (n) push(8'h00, pk(1'b0, 1'b0, 1'b0, 1'b0, model_rem));
   endtask

   // -1: coin missed; 0..P-1: sensor edge in that pulse cycle; P+k: sensor edge in wait cycle k.
   function automatic int pick_outcome(input int mode, input int att);
      int r;
      case (mode)
         1: return 1;
         2: return -1;
         3: return (att == 0) ? -1 : 1;
         default: begin
            r = $urandom_range(0, 7);
            if (r < 2) return -1;
            if (r < 6) return $urandom_range(0, P - 1);
            return P + $urandom_range(0, 5);
         end
      endcase
   endfunction

   task automatic build_txn(input int n, input int mode, input int abort_off);
      int rem, att, pick, ps, ws, wl, gs;
      logic [7:0] last;
      aborted  = 1'b0;
      abort_at = (abort_off > 0) ? stim_q.size() + abort_off : -1;
      if (n == 0) begin
         push(S_START, pk(1'b0, 1'b0, 1'b1, 1'b0, model_rem));
         push(8'h00, pk(1'b0, 1'b0, 1'b0, 1'b0, model_rem));
         return;
      end
      rem = n;
      att = 0;
      ps  = stim_q.size();
      push(S_START | 8'(n), pk(1'b0, 1'b1, 1'b0, 1'b1, 4'(rem)));
      repeat (P - 1) push(8'h00, pk(1'b0, 1'b1, 1'b0, 1'b1, 4'(rem)));
      while (!aborted) begin
         pick = pick_outcome(mode, att);
         ws   = stim_q.size();
         wl   = (pick < 0) ? S : ((pick < P) ? 1 : pick - P + 2);
         repeat (wl) push(8'h00, pk(1'b0, 1'b1, 1'b0, 1'b0, 4'(rem)));
         if (pick >= 0 && pick < P) patch_coin(ps + pick + 1);
         else if (pick >= P) patch_coin(ws + pick - P + 1);
         if (pick >= 0) begin
            att = 0;
            rem = rem - 1;
            if (rem == 0) begin
               push(8'h00, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
               push(8'h00, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
               break;
            end
         end else begin
            att = att + 1;
            if (att > MR) begin
               push(8'h00, pk(1'b1, 1'b1, 1'b0, 1'b0, 4'(rem)));
               push(S_START | 8'h01, pk(1'b1, 1'b1, 1'b0, 1'b0, 4'(rem)));
               push(8'h00, pk(1'b1, 1'b1, 1'b0, 1'b0, 4'(rem)));
               push(S_CLR, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'(rem)));
               break;
            end
         end
         gs = stim_q.size();
         repeat (G) push(8'h00, pk(1'b0, 1'b1, 1'b0, 1'b0, 4'(rem)));
         if (mode == 0 && $urandom_range(0, 1) == 1) patch_coin(gs + 1);
         ps = stim_q.size();
         repeat (P) push(8'h00, pk(1'b0, 1'b1, 1'b0, 1'b1, 4'(rem)));
      end
      last      = exp_q[exp_q.size() - 1];
      model_rem = last[3:0];
   endtask

   initial begin
      int n, ab;
      idle(2);
      build_txn(2, 1, 0);   idle(2);
      build_txn(0, 1, 0);   idle(2);
      build_txn(1, 3, 0);   idle(2);
      build_txn(3, 2, 0);   idle(2);
      build_txn(5, 1, 10);  idle(2);
      build_txn(1, 1, 0);   idle(2);
      build_txn(15, 1, 0);  idle(2);
      for (int t = 0; t < 30; t++) begin
         n  = $urandom_range(0, 6);
         ab = 0;
         if ($urandom_range(0, 3) == 0) begin
            if (n >= 2) ab = $urandom_range(1, 2 * P + G + 1);
            else if (n == 1) ab = $urandom_range(1, P);
         end
         build_txn(n, 0, ab);
         idle($urandom_range(1, 3));
      end

      #2 rst = 1'b0;
      #1 check("reset", obs, 8'h00);
      @(negedge clk);
      @(negedge clk);
      check("reset_hold", obs, 8'h00);
      rst = 1'b1;

      for (int i = 0; i < stim_q.size(); i++) begin
         {abort, fault_clr, start, coin_seen, amount} = stim_q[i];
         @(posedge clk);
         @(negedge clk);
         check($sformatf("step%0d", i), obs, exp_q[i]);
      end
      {abort, fault_clr, start, coin_seen, amount} = 8'h00;

      amount = 4'd3;
      start  = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      check("pre_rst_pulse", obs, pk(1'b0, 1'b1, 1'b0, 1'b1, 4'd3));
      rst = 1'b0;
      #1 check("async_rst", obs, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_rst_idle", obs, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
